// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-cache and D-cache line transfers.
// One full-line transfer outstanding at a time, with a watchdog on the wait for mem_ready.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              grant_d,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = 16;
    localparam bit          WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WD_LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } mem_cmd_t;

    state_t            state, state_next;
    mem_cmd_t          cmd, cmd_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              last_grant, last_next;
    logic              grant_next;
    logic [LINE_W-1:0] i_rdata_next, d_rdata_next;
    logic              i_ack_next, d_ack_next;
    logic              mem_req_next;
    logic              timeout_next;
    logic              pick_d_c;
    logic              wd_hit_c;

    assign mem_we    = cmd.we;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_next   = state;
        cmd_next     = cmd;
        cnt_next     = cnt;
        last_next    = last_grant;
        grant_next   = grant_d;
        i_rdata_next = i_rdata;
        d_rdata_next = d_rdata;
        i_ack_next   = 1'b0;
        d_ack_next   = 1'b0;
        mem_req_next = 1'b0;
        timeout_next = timeout_err;
        pick_d_c     = 1'b0;
        wd_hit_c     = WD_EN && (cnt == WD_LIMIT);

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    // On contention the side that did not win last time goes first.
                    pick_d_c     = d_req && (!i_req || !last_grant);
                    grant_next   = pick_d_c;
                    last_next    = pick_d_c;
                    cmd_next     = pick_d_c ? '{we: d_we, addr: d_addr, wdata: d_wdata}
                                            : '{we: i_we, addr: i_addr, wdata: i_wdata};
                    cnt_next     = '0;
                    mem_req_next = 1'b1;
                    state_next   = MEM;
                end
            end
            MEM: begin
                if (mem_ready || wd_hit_c) begin
                    // mem_ready wins over the watchdog; a timed-out read returns zeros.
                    if (!cmd.we) begin
                        if (grant_d) begin
                            d_rdata_next = mem_ready ? mem_rdata : '0;
                        end else begin
                            i_rdata_next = mem_ready ? mem_rdata : '0;
                        end
                    end
                    if (!mem_ready) begin
                        timeout_next = 1'b1;
                    end
                    i_ack_next = !grant_d;
                    d_ack_next = grant_d;
                    state_next = DONE;
                end else begin
                    cnt_next     = cnt + CNT_W'(1);
                    mem_req_next = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd         <= '0;
            cnt         <= '0;
            last_grant  <= 1'b1;
            grant_d     <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            mem_req     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            cmd         <= cmd_next;
            cnt         <= cnt_next;
            last_grant  <= last_next;
            grant_d     <= grant_next;
            i_rdata     <= i_rdata_next;
            d_rdata     <= d_rdata_next;
            i_ack       <= i_ack_next;
            d_ack       <= d_ack_next;
            mem_req     <= mem_req_next;
            timeout_err <= timeout_next;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: two instances (watchdog 8 and 1) share all stimulus.
module tb_cache_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 128;

    localparam logic [LINE_W-1:0] RD_A5 = {16{8'hA5}};
    localparam logic [LINE_W-1:0] RD_66 = {4{32'h6666_0006}};
    localparam logic [LINE_W-1:0] RD_C2 = {4{32'hC0DE_0002}};
    localparam logic [LINE_W-1:0] RD_55 = {16{8'h55}};
    localparam logic [LINE_W-1:0] WD_DB = {4{32'hDEAD_BEEF}};

    logic              clk, rst_n;
    logic              i_req, i_we, d_req, d_we, mem_ready;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] i_wdata, d_wdata, mem_rdata;

    logic              i_ack, d_ack, mem_req, mem_we, grant_d, timeout_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;

    logic              i_ack1, d_ack1, mem_req1, mem_we1, grant_d1, timeout_err1;
    logic [ADDR_W-1:0] mem_addr1;
    logic [LINE_W-1:0] i_rdata1, d_rdata1, mem_wdata1;

    int n_tests, n_fail;
    int ack_cnt, ack_cyc, d_seen, hi, n_ok;
    bit got;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant_d(grant_d), .timeout_err(timeout_err)
    );

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ack(i_ack1), .i_rdata(i_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant_d(grant_d1), .timeout_err(timeout_err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_mem_req", mem_req, 0);
        check("rst_acks", {i_ack, d_ack}, 0);
        check("rst_grant_d", grant_d, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", {i_rdata[7:0], d_rdata[7:0]}, 0);
        rst_n = 1'b1;

        // mem_ready in the first MEM cycle, which is also the TIMEOUT=1 limit
        i_req = 1'b1; i_addr = 32'h300; mem_ready = 1'b1; mem_rdata = RD_66;
        @(negedge clk);
        check("t6_mem_req", mem_req1, 1);
        check("t6_mem_addr", mem_addr1, 32'h300);
        check("t6_mem_we", mem_we1, 0);
        check("t6_mem_wdata", mem_wdata1, 0);
        check("t6_grant_d", grant_d1, 0);
        @(negedge clk);
        check("t6_i_ack", i_ack1, 1);
        check("t6_d_ack", d_ack1, 0);
        check("t6_i_rdata", i_rdata1, RD_66);
        check("t6_d_rdata", d_rdata1, 0);
        check("t6_timeout", timeout_err1, 0);
        check("t6_i_rdata_t8", i_rdata, RD_66);
        i_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);

        // I read 0x100, mem_ready 3 cycles after mem_req
        i_req = 1'b1; i_addr = 32'h100; mem_rdata = RD_A5;
        ack_cnt = 0; ack_cyc = 0; d_seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("t1_mem_req", mem_req, 1);
                check("t1_mem_addr", mem_addr, 32'h100);
                check("t1_mem_we", mem_we, 0);
            end
            if (i_ack) begin
                ack_cnt++;
                ack_cyc = c;
                i_req = 1'b0;
            end
            if (d_ack) d_seen++;
            mem_ready = (c == 4);
        end
        check("t1_ack_count", ack_cnt, 1);
        check("t1_ack_cycle", ack_cyc, 5);
        check("t1_i_rdata", i_rdata, RD_A5);
        check("t1_no_d_ack", d_seen, 0);
        check("t1_wd1_timeout", timeout_err1, 1);

        // Both requesters held after reset, mem_ready tied high
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h400; d_addr = 32'h500;
        mem_ready = 1'b1; mem_rdata = RD_C2;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("t2_i_ack_c%0d", c), i_ack, (c % 3 == 2) && ((c / 3) % 2 == 0));
            check($sformatf("t2_d_ack_c%0d", c), d_ack, (c % 3 == 2) && ((c / 3) % 2 == 1));
            check($sformatf("t2_mem_req_c%0d", c), mem_req, (c % 3 == 1));
            if (c % 3 == 1) check($sformatf("t2_grant_c%0d", c), grant_d, (c / 3) % 2);
            if (c == 11) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        check("t2_d_rdata", d_rdata, RD_C2);

        // D writeback: no rdata update
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = WD_DB; mem_rdata = RD_55;
        @(negedge clk);
        check("t3_mem_req", mem_req, 1);
        check("t3_mem_we", mem_we, 1);
        check("t3_mem_addr", mem_addr, 32'h2000);
        check("t3_mem_wdata", mem_wdata, WD_DB);
        check("t3_grant_d", grant_d, 1);
        @(negedge clk);
        check("t3_d_ack", d_ack, 1);
        check("t3_i_ack", i_ack, 0);
        check("t3_d_rdata", d_rdata, RD_C2);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);

        // Watchdog (TIMEOUT=8) on a D read that never sees mem_ready
        d_req = 1'b1; d_addr = 32'h3000; mem_ready = 1'b0;
        hi = 0; ack_cyc = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (mem_req) hi++;
            if (d_ack) begin
                ack_cyc = c;
                d_req = 1'b0;
            end
        end
        check("t4_mem_req_cycles", hi, 8);
        check("t4_ack_cycle", ack_cyc, 9);
        check("t4_d_rdata", d_rdata, 0);
        check("t4_timeout", timeout_err, 1);
        mem_ready = 1'b1;
        n_ok = 0;
        for (int k = 0; k < 20; k++) begin
            i_req = 1'b1;
            i_addr = 32'(k);
            got = 1'b0;
            for (int w = 0; w < 10; w++) begin
                @(negedge clk);
                if (i_ack) begin
                    got = 1'b1;
                    break;
                end
            end
            i_req = 1'b0;
            if (got) n_ok++;
            @(negedge clk);
        end
        check("t4_more_xfers", n_ok, 20);
        check("t4_timeout_sticky", timeout_err, 1);

        // Asynchronous reset in the middle of MEM
        i_req = 1'b1; d_req = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        check("t5_mem_req_pre", mem_req, 1);
        check("t5_grant_pre", grant_d, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_mem_req_async", mem_req, 0);
        check("t5_acks_async", {i_ack, d_ack}, 0);
        check("t5_timeout_clr", timeout_err, 0);
        check("t5_grant_clr", grant_d, 0);
        @(negedge clk);
        check("t5_acks_in_rst", {i_ack, d_ack}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_mem_req_post", mem_req, 1);
        check("t5_grant_post", grant_d, 0);
        mem_ready = 1'b1;
        @(negedge clk);
        check("t5_i_ack", i_ack, 1);
        check("t5_d_ack", d_ack, 0);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
